// File: rtl/order_book_pkg.sv
`default_nettype none
// ============================================================================
// Module   : order_book_pkg
// Purpose  : Shared types and constants for the order-book memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package order_book_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 129;

  // Requester indices into the request vectors
  localparam int REQ_ADD    = 0;
  localparam int REQ_CANCEL = 1;
  localparam int REQ_EXEC   = 2;

  typedef struct packed {
    logic              wr_valid;
    logic              rd_valid;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
  } memory_request_t;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage : order_book_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker; one-hot grant to the first
//            active request at or above the pointer, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  // Scan from the pointer upward and grant the first requester found
  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/order_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : order_mem_arbiter
// Purpose  : Round-robin arbiter for the single-port order-book entry memory
//            with lock support for atomic read-modify-write sequences and
//            read-data routing back to the issuing engine.
// Revision : 1.0 - initial release
// ============================================================================
module order_mem_arbiter
  import order_book_pkg::memory_request_t, order_book_pkg::arb_state_e,
         order_book_pkg::ARB, order_book_pkg::LOCKED;
#(
  parameter int N_REQ      = 3,
  parameter int ADDR_W     = order_book_pkg::ADDR_W,
  parameter int DATA_W     = order_book_pkg::DATA_W,
  parameter int MEM_RD_LAT = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_wr,
  input  logic [N_REQ-1:0]          req_rd,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_wr_valid,
  output logic                      mem_rd_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      lock_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state_q;
  logic [PTR_W-1:0] owner_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             lock_err_q;

  memory_request_t  cmd_q;
  logic [PTR_W-1:0] cmd_id_q;

  logic [MEM_RD_LAT-1:0]            tag_v_q;
  logic [MEM_RD_LAT-1:0][PTR_W-1:0] tag_id_q;
  logic [N_REQ-1:0]                 rsp_valid_q;
  logic [DATA_W-1:0]                rsp_data_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic              acc;
  logic [PTR_W-1:0]  acc_id;
  logic              acc_wr;
  logic              acc_rd;
  logic              acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [PTR_W-1:0]  acc_ptr_d;
  logic [PTR_W-1:0]  owner_ptr_d;
  logic              lock_expired;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt)
  );

  assign lock_expired = (lock_cnt_q == CNT_W'(LOCK_MAX));

  // Ready: round-robin grant when arbitrating, owner-only while locked
  // (owner loses ready in the cycle the lock counter expires)
  always_comb begin
    req_ready = '0;
    if (state_q == ARB) begin
      req_ready = arb_gnt;
    end else if (!lock_expired) begin
      req_ready[owner_q] = req_valid[owner_q];
    end
  end

  // Decode the accepted beat (ready is one-hot or zero)
  always_comb begin
    acc    = 1'b0;
    acc_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc    = 1'b1;
        acc_id = PTR_W'(i);
      end
    end
    acc_wr      = req_wr[acc_id];
    acc_rd      = req_rd[acc_id];
    acc_lock    = req_lock[acc_id];
    acc_addr    = req_addr[acc_id*ADDR_W +: ADDR_W];
    acc_wdata   = req_wdata[acc_id*DATA_W +: DATA_W];
    acc_ptr_d   = (int'(acc_id) + 1 >= N_REQ) ? '0 : acc_id + PTR_W'(1);
    owner_ptr_d = (int'(owner_q) + 1 >= N_REQ) ? '0 : owner_q + PTR_W'(1);
  end

  // Arbitration FSM: round-robin pointer, lock ownership, lock timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      if (acc) begin
        rr_ptr_q <= acc_ptr_d;
      end
      case (state_q)
        ARB: begin
          if (acc && acc_lock) begin
            state_q    <= LOCKED;
            owner_q    <= acc_id;
            lock_cnt_q <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (acc && !acc_lock) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (lock_expired) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b1;
            rr_ptr_q   <= owner_ptr_d;
          end else begin
            lock_cnt_q <= lock_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // Memory command register; write wins over read, empty beats issue nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= '0;
      cmd_id_q <= '0;
    end else begin
      cmd_q.wr_valid <= acc && acc_wr;
      cmd_q.rd_valid <= acc && !acc_wr && acc_rd;
      if (acc) begin
        cmd_q.address <= acc_addr;
        cmd_q.data_in <= acc_wdata;
        cmd_id_q      <= acc_id;
      end
    end
  end

  // Tag pipeline tracks read ownership until data returns, then registers
  // the response toward the issuing requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag_v_q[0]  <= cmd_q.rd_valid;
      tag_id_q[0] <= cmd_id_q;
      for (int s = 1; s < MEM_RD_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      rsp_valid_q <= '0;
      if (tag_v_q[MEM_RD_LAT-1]) begin
        rsp_valid_q[tag_id_q[MEM_RD_LAT-1]] <= 1'b1;
        rsp_data_q                          <= mem_rdata;
      end
    end
  end

  assign mem_wr_valid = cmd_q.wr_valid;
  assign mem_rd_valid = cmd_q.rd_valid;
  assign mem_addr     = cmd_q.address;
  assign mem_wdata    = cmd_q.data_in;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign lock_err     = lock_err_q;

endmodule : order_mem_arbiter
`default_nettype wire

// File: tb/tb_order_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_mem_arbiter
// Purpose  : Directed self-checking bench for order_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_mem_arbiter;
  import order_book_pkg::*;

  localparam int NR = 3;

  localparam logic [DATA_W-1:0] ENTRY5 = {1'b1, 64'd100, 32'd10, 32'd7};
  localparam logic [DATA_W-1:0] WDATA3 = {1'b1, 64'd250, 32'd5, 32'd42};
  localparam logic [DATA_W-1:0] WDATA9 = {1'b0, 64'hDEAD_BEEF_0000_1234, 32'd77, 32'd9};

  logic                   clk;
  logic                   rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          req_wr;
  logic [NR-1:0]          req_rd;
  logic [NR-1:0]          req_lock;
  logic [NR*ADDR_W-1:0]   req_addr;
  logic [NR*DATA_W-1:0]   req_wdata;
  logic [NR-1:0]          rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   mem_wr_valid;
  logic                   mem_rd_valid;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   lock_err;

  int n_checks;
  int n_fail;

  order_mem_arbiter #(
    .N_REQ      (NR),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_RD_LAT (1),
    .LOCK_MAX   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_rd       (req_rd),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_rd_valid (mem_rd_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .lock_err     (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the entry memory as seen by reads
  function automatic logic [DATA_W-1:0] entry_at(input logic [ADDR_W-1:0] a);
    logic [63:0] price;
    logic [31:0] qty;
    logic [31:0] oid;
    if (a == 10'd5) return ENTRY5;
    price = 64'(a) * 64'd3;
    qty   = 32'(a);
    oid   = 32'(a) + 32'd1;
    return {1'b0, price, qty, oid};
  endfunction

  // Single-port memory model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_valid) mem_rdata <= entry_at(mem_addr);
  end

  task automatic clear_inputs();
    req_valid = '0;
    req_wr    = '0;
    req_rd    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic rd,
                         input logic lk, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_wr[i]    = wr;
    req_rd[i]    = rd;
    req_lock[i]  = lk;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Leaves the bench at a falling edge with reset just released
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, mem_wr_valid, mem_rd_valid, mem_addr, mem_wdata, lock_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rsp_valid=%b wr=%b rd=%b addr=%h lock_err=%b expected all zero",
               rsp_valid, mem_wr_valid, mem_rd_valid, mem_addr, lock_err);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, mem_wr_valid, mem_rd_valid, lock_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b rsp_valid=%b wr=%b rd=%b lock_err=%b expected all zero",
               req_ready, rsp_valid, mem_wr_valid, mem_rd_valid, lock_err);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(REQ_CANCEL, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5, '0);
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL read_ready: got %b expected %b", req_ready, 3'b010);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if ({mem_rd_valid, mem_wr_valid, mem_addr} !== {1'b1, 1'b0, 10'd5}) begin
      n_fail++; $display("FAIL read_cmd: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=005",
                         mem_rd_valid, mem_wr_valid, mem_addr);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({mem_rd_valid, rsp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL read_gap: got rd=%b rsp_valid=%b expected 0 000", mem_rd_valid, rsp_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 3'b010) begin
      n_fail++; $display("FAIL read_rsp_valid: got %b expected %b", rsp_valid, 3'b010);
    end
    n_checks++;
    if (rsp_data !== ENTRY5) begin
      n_fail++; $display("FAIL read_rsp_data: got %h expected %h", rsp_data, ENTRY5);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL read_rsp_single: got %b expected 000", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 3'b001 << (k % NR);
      #1;
      n_checks++;
      if (req_ready !== exp_gnt) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_gnt);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0]     exp_gnt;
    logic [ADDR_W-1:0] a;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a = ADDR_W'(20 + i);
      set_req(i, 1'b1, 1'b0, 1'b1, 1'b0, a, '0);
    end
    for (int k = 0; k < NR; k++) begin
      exp_gnt = 3'b001 << k;
      #1;
      n_checks++;
      if (req_ready !== exp_gnt) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, req_ready, exp_gnt);
      end
      @(negedge clk);
    end
    clear_inputs();
    for (int k = 0; k < NR; k++) begin
      exp_gnt = 3'b001 << k;
      a = ADDR_W'(20 + k);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_data} !== {exp_gnt, entry_at(a)}) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got %b/%h expected %b/%h",
                           k, rsp_valid, rsp_data, exp_gnt, entry_at(a));
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++; $display("FAIL b2b_rsp_end: got %b expected 000", rsp_valid);
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    // locked read by cancel
    set_req(REQ_CANCEL, 1'b1, 1'b0, 1'b1, 1'b1, 10'd3, '0);
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL lock_first_ready: got %b expected 010", req_ready);
    end
    @(negedge clk);
    // owner idle, others contend
    set_req(REQ_CANCEL, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(REQ_ADD,    1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(REQ_EXEC,   1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++; $display("FAIL lock_hold_ready: got %b expected 000", req_ready);
    end
    n_checks++;
    if ({mem_rd_valid, mem_addr} !== {1'b1, 10'd3}) begin
      n_fail++; $display("FAIL lock_rd_cmd: got rd=%b addr=%h expected rd=1 addr=003", mem_rd_valid, mem_addr);
    end
    @(negedge clk);
    // release beat: unlocked write of addr 3
    set_req(REQ_CANCEL, 1'b1, 1'b1, 1'b0, 1'b0, 10'd3, WDATA3);
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL lock_release_ready: got %b expected 010", req_ready);
    end
    @(negedge clk);
    set_req(REQ_CANCEL, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++; $display("FAIL lock_after_release: got %b expected 100", req_ready);
    end
    n_checks++;
    if ({mem_wr_valid, mem_addr, mem_wdata} !== {1'b1, 10'd3, WDATA3}) begin
      n_fail++; $display("FAIL lock_wr_cmd: got wr=%b addr=%h data=%h expected wr=1 addr=003 data=%h",
                         mem_wr_valid, mem_addr, mem_wdata, WDATA3);
    end
    n_checks++;
    if ({rsp_valid, rsp_data} !== {3'b010, entry_at(10'd3)}) begin
      n_fail++; $display("FAIL lock_rd_rsp: got %b/%h expected 010/%h", rsp_valid, rsp_data, entry_at(10'd3));
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    set_req(REQ_ADD, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL to_lock_ready: got %b expected 001", req_ready);
    end
    @(negedge clk);
    set_req(REQ_ADD,    1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(REQ_CANCEL, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 16; k++) begin
      // owner returns in the expiring cycle; it must not be accepted
      if (k == 16) set_req(REQ_ADD, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      n_checks++;
      if ({req_ready, lock_err} !== 4'b0000) begin
        n_fail++; $display("FAIL to_locked[%0d]: got ready=%b lock_err=%b expected 000 0", k, req_ready, lock_err);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL to_next_grant: got %b expected 010", req_ready);
    end
    n_checks++;
    if (lock_err !== 1'b1) begin
      n_fail++; $display("FAIL to_lock_err: got %b expected 1", lock_err);
    end
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (lock_err !== 1'b1) begin
      n_fail++; $display("FAIL to_lock_err_sticky: got %b expected 1", lock_err);
    end
  endtask

  task automatic test_wr_priority();
    do_reset();
    set_req(REQ_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 10'd9, WDATA9);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL wrp_ready: got %b expected 001", req_ready);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if ({mem_wr_valid, mem_rd_valid, mem_addr, mem_wdata} !== {1'b1, 1'b0, 10'd9, WDATA9}) begin
      n_fail++; $display("FAIL wrp_cmd: got wr=%b rd=%b addr=%h data=%h expected wr=1 rd=0 addr=009 data=%h",
                         mem_wr_valid, mem_rd_valid, mem_addr, mem_wdata, WDATA9);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_wr_valid, mem_rd_valid, rsp_valid} !== 5'b00000) begin
        n_fail++; $display("FAIL wrp_quiet[%0d]: got wr=%b rd=%b rsp_valid=%b expected 0 0 000",
                           k, mem_wr_valid, mem_rd_valid, rsp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(REQ_CANCEL, 1'b1, 1'b0, 1'b1, 1'b0, 10'd5, '0);
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++;
    if (mem_rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_cmd: got %b expected 1", mem_rd_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, mem_wr_valid, mem_rd_valid, mem_addr, mem_wdata, lock_err} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got rd=%b addr=%h rsp_valid=%b expected all zero",
                         mem_rd_valid, mem_addr, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, mem_rd_valid} !== 4'b0000) begin
        n_fail++; $display("FAIL rstmid_no_rsp[%0d]: got rsp_valid=%b rd=%b expected 000 0", k, rsp_valid, mem_rd_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_lock_release();
    test_lock_timeout();
    test_wr_priority();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_order_mem_arbiter
`default_nettype wire

// File: doc/order_mem_arbiter.md
# order_mem_arbiter

Arbitrates the single-port order-book entry memory between the order-processing engines: add, cancel and execute. Each engine issues read or write requests over a valid/ready handshake. The arbiter grants one request per cycle in round-robin order and drives a registered command to the memory. Read data is routed back to the issuing engine. A lock mechanism lets one engine hold the memory for an atomic read-modify-write sequence.

## Interface
- `N_REQ`, 3: number of requesters; index 0 = add, 1 = cancel, 2 = execute.
- `ADDR_W`, 10: entry address width (1024 entries).
- `DATA_W`, 129: entry width, packed as {entry_valid, price[63:0], quantity[31:0], order_id[31:0]}.
- `MEM_RD_LAT`, 1: memory read latency in cycles, from command to `mem_rdata` (≥1).
- `LOCK_MAX`, 16: maximum number of cycles a lock may be held.
- `clk`  in  1  sole clock; every register is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_wr`  in  N_REQ  1 = write.
- `req_rd`  in  N_REQ  1 = read.
- `req_lock`  in  N_REQ  1 = keep the grant after this beat.
- `req_addr`  in  N_REQ×ADDR_W  request address.
- `req_wdata`  in  N_REQ×DATA_W  write data.
- `rsp_valid`  out  N_REQ  one-hot read-data valid.
- `rsp_data`  out  DATA_W  read data, shared across requesters.
- `mem_wr_valid`, `mem_rd_valid`  out  1 each  memory command.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `lock_err`  out  1  sticky flag: a lock timed out.

## Operation
- A beat is accepted when `req_valid[i] && req_ready[i]` in the same cycle. `req_ready` is combinational from the current `req_valid`, the state and the pointer.
- **State ARB:**
  - Grant the first valid requester scanning from `rr_ptr` upward, wrapping modulo N_REQ.
  - On acceptance from requester i, set `rr_ptr` = (i+1) mod N_REQ.
  - If `req_lock[i]`=1 on that beat, set owner = i and go to LOCKED.
- **State LOCKED:**
  - `req_ready[owner]` = `req_valid[owner]`; all other ready bits are 0.
  - The lock counter starts at 1 on entry and increments every cycle, whether or not the owner is active.
  - An accepted owner beat with `req_lock`=0 is the release beat; that beat is performed, then the arbiter returns to ARB.
  - If the counter reaches LOCK_MAX without a release beat: return to ARB, set `lock_err`, and leave `rr_ptr` = owner+1.
- **Commands:**
  - Write takes priority: if `req_wr`=1, the beat is a write and `req_rd` is ignored.
  - A beat with both `req_wr`=0 and `req_rd`=0 is accepted and produces no memory command.
- **Responses:**
  - Each read command pushes the requester id into a tag shift pipeline MEM_RD_LAT deep.
  - When a tag emerges, `rsp_valid[id]`=1 and `rsp_data`=`mem_rdata`, registered.
  - Requesters cannot stall responses; there is no backpressure on the response path.
- **Reset values:** all outputs 0, `rr_ptr`=0, state ARB, lock counter 0, tag pipeline empty.
- **Reset mid-operation:** in-flight reads are dropped; no `rsp_valid` is issued for them after reset.

## Timing
- Throughput: one accepted beat per cycle.
- Memory command: registered; asserted 1 cycle after acceptance, for exactly 1 cycle.
- Read response: `rsp_valid` asserted 1 + MEM_RD_LAT + 1 cycles after acceptance (3 cycles at the defaults), for 1 cycle.
- Back-to-back reads: responses return in issue order, one per cycle.
- Release beat followed by contention: the cycle after the release, ARB scans from owner+1.
- Timeout: in the cycle where the counter equals LOCK_MAX, owner ready is already 0 and the other requesters become eligible in the following cycle. `lock_err` rises the cycle after the timeout and stays set until reset.

## Structure
- Package `order_book_pkg`:
  - `memory_request` struct {wr_valid, rd_valid, address[ADDR_W-1:0], data_in[DATA_W-1:0]}.
  - ADDR_W and DATA_W constants.
  - Requester ids REQ_ADD=0, REQ_CANCEL=1, REQ_EXEC=2.
  - State enum {ARB, LOCKED}.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs: request vector, pointer. Output: one-hot grant vector.
- Top level: FSM, lock counter, command register and tag pipeline.

## Test plan
- Requester 1 reads addr 0x005 holding {1, 64'd100, 32'd10, 32'd7}: `mem_rd_valid` asserted on cycle +1; `rsp_valid`=3'b010 with that data on cycle +3.
- All three requesters valid continuously from reset: grants go 0,1,2,0,1,2, one per cycle, and `req_ready` is always one-hot.
- Requester 1 issues a locked read of addr 3, then an unlocked write of addr 3 while 0 and 2 stay valid: no grant to 0 or 2 between the two beats; the next grant after the release goes to requester 2.
- Requester 0 locks and then drops valid: the arbiter leaves LOCKED after 16 cycles, `lock_err`=1, and requester 1 is granted next.
- Requester 0 asserts both `req_wr` and `req_rd` for addr 9: exactly one `mem_wr_valid`, no `mem_rd_valid`, no response.
- `rst` asserted 1 cycle after a read is accepted: all outputs go 0 immediately and no `rsp_valid` appears after reset is released.
